// File: rtl/uart_text_cmd_parser.sv
// UART byte-stream to text/colour buffer command parser with ESC sequences.
// Optional echo path to UART TX enabled by defining UART_TEXT_CMD_PARSER_ECHO_EN.
module uart_text_cmd_parser #(
    parameter int MAX_CHARS = 8,
    parameter int IDX_W     = $clog2(MAX_CHARS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       num_chars,
    input  logic [3:0]       rnd_color,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_addr,
    output logic [7:0]       wr_char,
    output logic [3:0]       wr_color,
    output logic [IDX_W-1:0] cursor,
    output logic [7:0]       echo_data,
    output logic             echo_valid,
    input  logic             echo_ready
);

    typedef enum logic [2:0] {IDLE, ESC, ARG_POS, ARG_COL, CLEAR} state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] cursor_d, clr_cnt, clr_cnt_d, wr_addr_d;
    logic [IDX_W-1:0] cursor_next, arg_pos;
    logic             wr_en_d, rand_mode, rand_mode_d;
    logic [7:0]       wr_char_d;
    logic [3:0]       wr_color_d, fixed_color, fixed_color_d;
    logic             echo_stall, xfer;

    assign in_ready    = !reset && (state != CLEAR) && !echo_stall;
    assign xfer        = in_valid && in_ready;
    assign arg_pos     = in_data[IDX_W-1:0];
    // Same wrap rule as the refresh engine: last used cell is num_chars.
    assign cursor_next = (int'(cursor) < int'(num_chars)) ? cursor + IDX_W'(1) : '0;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d       = state;
        cursor_d      = cursor;
        clr_cnt_d     = clr_cnt;
        fixed_color_d = fixed_color;
        rand_mode_d   = rand_mode;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr;
        wr_char_d     = wr_char;
        wr_color_d    = wr_color;

        unique case (state)
            IDLE: if (xfer) begin
                if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = cursor;
                    wr_char_d  = in_data;
                    wr_color_d = rand_mode ? rnd_color : fixed_color;
                    cursor_d   = cursor_next;
                end else if (in_data == 8'h0D) begin
                    cursor_d = '0;
                end else if (in_data == 8'h1B) begin
                    state_d = ESC;
                end
            end
            ESC: if (xfer) begin
                state_d = IDLE;
                case (in_data)
                    8'h43: begin
                        // Cell 0 is written on the 'C' edge so the clear starts immediately.
                        state_d    = CLEAR;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = '0;
                        wr_char_d  = 8'h00;
                        wr_color_d = 4'h0;
                        clr_cnt_d  = IDX_W'(1);
                    end
                    8'h50:   state_d = ARG_POS;
                    8'h4B:   state_d = ARG_COL;
                    8'h52:   rand_mode_d = 1'b1;
                    default: ;
                endcase
            end
            ARG_POS: if (xfer) begin
                cursor_d = (int'(arg_pos) <= int'(num_chars)) ? arg_pos : '0;
                state_d  = IDLE;
            end
            ARG_COL: if (xfer) begin
                fixed_color_d = in_data[3:0];
                rand_mode_d   = 1'b0;
                state_d       = IDLE;
            end
            CLEAR: begin
                // clr_cnt wraps to zero once the last cell has been issued.
                if (clr_cnt == '0) begin
                    cursor_d = '0;
                    state_d  = IDLE;
                end else begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = clr_cnt;
                    wr_char_d  = 8'h00;
                    wr_color_d = 4'h0;
                    clr_cnt_d  = clr_cnt + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state       <= IDLE;
            cursor      <= '0;
            clr_cnt     <= '0;
            fixed_color <= 4'h0;
            rand_mode   <= 1'b1;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_char     <= 8'h00;
            wr_color    <= 4'h0;
        end else begin
            state       <= state_d;
            cursor      <= cursor_d;
            clr_cnt     <= clr_cnt_d;
            fixed_color <= fixed_color_d;
            rand_mode   <= rand_mode_d;
            wr_en       <= wr_en_d;
            wr_addr     <= wr_addr_d;
            wr_char     <= wr_char_d;
            wr_color    <= wr_color_d;
        end
    end

`ifdef UART_TEXT_CMD_PARSER_ECHO_EN
    // Single-entry echo buffer; input stalls rather than dropping a byte.
    assign echo_stall = echo_valid && !echo_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_valid <= 1'b0;
            echo_data  <= 8'h00;
        end else if (xfer) begin
            echo_valid <= 1'b1;
            echo_data  <= in_data;
        end else if (echo_ready) begin
            echo_valid <= 1'b0;
        end
    end
`else
    logic unused_echo_ready;
    assign unused_echo_ready = echo_ready;
    assign echo_stall        = 1'b0;
    assign echo_valid        = 1'b0;
    assign echo_data         = 8'h00;
`endif

endmodule
